// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a two-entry skid buffer.
// Also provides flush-to-bubble and a saturating count of stalled output cycles.
module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 111,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              r_out_v;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_data;
  logic              r_skid_v;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_accept;
  logic w_drain;
  logic w_stalled;

  // NOTE: ready_o is taken straight from the skid flop, so back-pressure never
  // forms a combinational path from ready_i to the upstream stage.
  assign w_accept  = valid_i & ~r_skid_v;
  assign w_drain   = r_out_v & ready_i;
  assign w_stalled = r_out_v & ~ready_i;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_v     <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= '0;
      r_skid_v    <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stalled && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end

      if (flush_i) begin
        // Bubble: control is zeroed, payload is left as-is.
        r_out_v     <= 1'b0;
        r_out_ctrl  <= '0;
        r_skid_v    <= 1'b0;
        r_skid_ctrl <= '0;
      end else if (!r_out_v) begin
        if (w_accept) begin
          r_out_v    <= 1'b1;
          r_out_ctrl <= ctrl_i;
          r_out_data <= data_i;
        end
      end else if (w_drain) begin
        if (r_skid_v) begin
          r_out_ctrl  <= r_skid_ctrl;
          r_out_data  <= r_skid_data;
          r_skid_v    <= 1'b0;
          r_skid_ctrl <= '0;
        end else if (w_accept) begin
          r_out_ctrl <= ctrl_i;
          r_out_data <= data_i;
        end else begin
          r_out_v    <= 1'b0;
          r_out_ctrl <= '0;
        end
      end else if (w_accept) begin
        r_skid_v    <= 1'b1;
        r_skid_ctrl <= ctrl_i;
        r_skid_data <= data_i;
      end
    end
  end

  assign ready_o     = ~r_skid_v;
  assign valid_o     = r_out_v;
  assign ctrl_o      = r_out_ctrl;
  assign data_o      = r_out_data;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, skid fill/drain, flush, async reset
// and counter saturation (second instance with a 3-bit counter).
module tb_pipe_stage_skid;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 111;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [15:0]       stall_cnt_o;

  logic              ready3_o;
  logic              valid3_o;
  logic [CTRL_W-1:0] ctrl3_o;
  logic [DATA_W-1:0] data3_o;
  logic [2:0]        stall_cnt3_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready3_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .valid_o(valid3_o),
    .ready_i(ready_i), .ctrl_o(ctrl3_o), .data_o(data3_o), .stall_cnt_o(stall_cnt3_o)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [15:0] d, input logic rdy);
    valid_i = v;
    ctrl_i  = c;
    data_i  = DATA_W'(d);
    ready_i = rdy;
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    drive(1'b0, 8'h00, 16'h0, 1'b0);
    #1;
    check("rst_valid", 128'(valid_o), 128'd0);
    check("rst_ctrl",  128'(ctrl_o),  128'd0);
    check("rst_data",  128'(data_o),  128'd0);
    check("rst_cnt",   128'(stall_cnt_o), 128'd0);
    check("rst_ready", 128'(ready_o), 128'd1);
    step();
    rst_i = 1'b0;

    // Full-throughput stream 1..4.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), 16'(i), 1'b1);
      step();
      check($sformatf("str_data%0d", i), 128'(data_o), 128'(i));
      check($sformatf("str_ctrl%0d", i), 128'(ctrl_o), 128'(8'h10 + i));
      check($sformatf("str_valid%0d", i), 128'(valid_o), 128'd1);
      check($sformatf("str_ready%0d", i), 128'(ready_o), 128'd1);
    end
    drive(1'b0, 8'h77, 16'h0, 1'b1);
    step();
    check("drain_valid", 128'(valid_o), 128'd0);
    check("drain_ctrl",  128'(ctrl_o),  128'd0);
    check("drain_data",  128'(data_o),  128'd4);
    check("str_cnt",     128'(stall_cnt_o), 128'd0);

    // Skid fill with A,B,C, then release.
    drive(1'b1, 8'hA1, 16'h000A, 1'b1);
    step();
    check("sk_a_data", 128'(data_o), 128'h0A);
    drive(1'b1, 8'hB1, 16'h000B, 1'b0);
    step();
    check("sk_hold_a",   128'(data_o),  128'h0A);
    check("sk_ready_lo", 128'(ready_o), 128'd0);
    drive(1'b1, 8'hC1, 16'h000C, 1'b0);
    step();
    check("sk_hold_a2", 128'(data_o), 128'h0A);
    check("sk_ready_lo2", 128'(ready_o), 128'd0);
    check("sk_cnt", 128'(stall_cnt_o), 128'd2);
    ready_i = 1'b1;
    step();
    check("sk_b_data",  128'(data_o),  128'h0B);
    check("sk_b_ctrl",  128'(ctrl_o),  128'hB1);
    check("sk_b_valid", 128'(valid_o), 128'd1);
    check("sk_ready_hi", 128'(ready_o), 128'd1);
    step();
    check("sk_c_data",  128'(data_o),  128'h0C);
    check("sk_c_valid", 128'(valid_o), 128'd1);
    valid_i = 1'b0;
    step();
    check("sk_end_valid", 128'(valid_o), 128'd0);
    check("sk_end_cnt", 128'(stall_cnt_o), 128'd2);

    // Fill out and skid, then flush with a valid input carrying ctrl 8'hFF.
    drive(1'b1, 8'h21, 16'h0011, 1'b0);
    step();
    drive(1'b1, 8'h22, 16'h0022, 1'b0);
    step();
    check("fl_full_ready", 128'(ready_o), 128'd0);
    drive(1'b1, 8'hFF, 16'h0033, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("fl_valid", 128'(valid_o), 128'd0);
    check("fl_ctrl",  128'(ctrl_o),  128'd0);
    check("fl_ready", 128'(ready_o), 128'd1);
    check("fl_data",  128'(data_o),  128'h11);
    check("fl_cnt",   128'(stall_cnt_o), 128'd4);
    drive(1'b0, 8'h00, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fl_quiet%0d", i), 128'(valid_o), 128'd0);
    end

    // Async reset between edges with two entries held.
    drive(1'b1, 8'h41, 16'h0041, 1'b0);
    step();
    drive(1'b1, 8'h42, 16'h0042, 1'b0);
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_valid", 128'(valid_o), 128'd0);
    check("ar_ctrl",  128'(ctrl_o),  128'd0);
    check("ar_ready", 128'(ready_o), 128'd1);
    check("ar_cnt",   128'(stall_cnt_o), 128'd0);
    step();
    rst_i = 1'b0;
    drive(1'b1, 8'h55, 16'h0055, 1'b1);
    step();
    check("ar_load_data",  128'(data_o),  128'h55);
    check("ar_load_valid", 128'(valid_o), 128'd1);

    // Saturation: hold output valid with ready_i=0 for 10 edges.
    drive(1'b0, 8'h00, 16'h0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("sat3_%0d", k), 128'(stall_cnt3_o), 128'((k > 7) ? 7 : k));
    end
    check("sat16", 128'(stall_cnt_o), 128'd10);
    check("sat_hold_data", 128'(data_o), 128'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
